// File: rtl/cvp14_pkg.sv
// cvp14 shared types and constants
// error codes, burst states, helpers
package cvp14_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RDWR  = 2'b01,
    ERR_OOR   = 2'b10,
    ERR_LDCOL = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } burst_e;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [4:0] sat_inc5(
    input logic [4:0] v
  );
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/cvp14_mem_array.sv
// cvp14 word array, one write port,
// one registered read port
module cvp14_mem_array
  import cvp14_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // write commits at the edge; a read on a later edge sees it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cvp14_mem_responder.sv
// cvp14 bus-side memory responder
// fixed-latency reads, error/burst tracking
module cvp14_mem_responder
  import cvp14_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] BASE     = 16'h0000,
  parameter int          READ_LAT = 1
) (
  input  logic              Clk1,
  input  logic              Reset_n,
  input  logic [15:0]       Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [15:0]       WData,
  output logic [15:0]       RData,
  output logic              RValid,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [15:0]       LdData,
  output logic [1:0]        ErrCode,
  output logic [15:0]       RdCnt,
  output logic [15:0]       WrCnt,
  output logic [4:0]        BurstLen
);

  logic [16:0]       diff;
  logic              in_rng;
  logic [ADDR_W-1:0] idx;
  logic              rd_acc, wr_acc, rd_wr;
  logic              oor_op, ld_col, wr_do;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [15:0]       mem_wd;
  logic [15:0]       mem_rd;

  logic              s0_vld_q, s0_vld_d;
  logic              s0_oor_q, s0_oor_d;
  logic [15:0]       s0_dat;
  logic              tl_vld;
  logic [15:0]       tl_dat;

  logic [15:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  err_e              err_q, err_d;
  logic [15:0]       rdcnt_q, rdcnt_d;
  logic [15:0]       wrcnt_q, wrcnt_d;
  logic [4:0]        blen_q, blen_d;
  burst_e            st_q, st_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       prev_q, prev_d;
  logic              same_op, seq, same;

  // address decode and request classification
  always_comb begin
    diff   = {1'b0, Addr} - {1'b0, BASE};
    in_rng = !diff[16] &&
             ((diff[15:0] >> ADDR_W) == 16'd0);
    idx    = diff[ADDR_W-1:0];
    rd_acc = RD && !WR;
    wr_acc = WR && !RD;
    rd_wr  = RD && WR;
    oor_op = (rd_acc || wr_acc) && !in_rng;
    ld_col = LdEn && wr_acc && in_rng;
    wr_do  = Reset_n && wr_acc && in_rng && !LdEn;
  end

  // preload owns the write port when both want it
  always_comb begin
    mem_we = LdEn || wr_do;
    mem_wa = LdEn ? LdAddr : idx;
    mem_wd = LdEn ? LdData : WData;
  end

  cvp14_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_arr (
    .clk  (Clk1),
    .we   (mem_we),
    .waddr(mem_wa),
    .wdata(mem_wd),
    .re   (rd_acc),
    .raddr(idx),
    .rdata(mem_rd)
  );

  assign s0_dat = s0_oor_q ? 16'h0000 : mem_rd;

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign tl_vld = s0_vld_q;
      assign tl_dat = s0_dat;
    end else begin : g_latn
      localparam int N = READ_LAT - 1;
      logic [N-1:0] pv_q, pv_d;
      logic [15:0]  pd_q [N];
      logic [15:0]  pd_d [N];

      // extra delay stages behind the array read
      always_comb begin
        pv_d[0] = s0_vld_q;
        pd_d[0] = s0_dat;
        for (int i = 1; i < N; i++) begin
          pv_d[i] = pv_q[i-1];
          pd_d[i] = pd_q[i-1];
        end
      end

      // stage register; reset drops in-flight reads
      always_ff @(posedge Clk1) begin
        if (!Reset_n) pv_q <= '0;
        else          pv_q <= pv_d;
        pd_q <= pd_d;
      end

      assign tl_vld = pv_q[N-1];
      assign tl_dat = pd_q[N-1];
    end
  endgenerate

  // read path, error, counters and burst FSM next state
  always_comb begin
    s0_vld_d = rd_acc;
    s0_oor_d = !in_rng;
    rvalid_d = tl_vld;
    rdata_d  = tl_vld ? tl_dat : rdata_q;

    err_d = err_q;
    if (err_q == ERR_NONE) begin
      unique case (1'b1)
        rd_wr:   err_d = ERR_RDWR;
        oor_op:  err_d = ERR_OOR;
        ld_col:  err_d = ERR_LDCOL;
        default: err_d = err_q;
      endcase
    end

    rdcnt_d = rd_acc ? sat_inc16(rdcnt_q) : rdcnt_q;
    wrcnt_d = wr_do  ? sat_inc16(wrcnt_q) : wrcnt_q;

    seq     = (Addr == prev_q + 16'd1);
    same    = (Addr == prev_q);
    same_op = (st_q == RBURST && rd_acc) ||
              (st_q == WBURST && wr_acc);
    prev_d  = (rd_acc || wr_acc) ? Addr : prev_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    blen_d  = blen_q;

    if (st_q != IDLE && same_op && (seq || same)) begin
      if (seq) cnt_d = sat_inc5(cnt_q);
    end else begin
      if (st_q != IDLE) blen_d = cnt_q;
      st_d = IDLE;
      if (rd_acc) begin
        st_d  = RBURST;
        cnt_d = 5'd1;
      end else if (wr_acc) begin
        st_d  = WBURST;
        cnt_d = 5'd1;
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge Clk1) begin
    if (!Reset_n) begin
      s0_vld_q <= 1'b0;
      s0_oor_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= ERR_NONE;
      rdcnt_q  <= '0;
      wrcnt_q  <= '0;
      blen_q   <= '0;
      st_q     <= IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
    end else begin
      s0_vld_q <= s0_vld_d;
      s0_oor_q <= s0_oor_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdcnt_q  <= rdcnt_d;
      wrcnt_q  <= wrcnt_d;
      blen_q   <= blen_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
    end
  end

  assign RData    = rdata_q;
  assign RValid   = rvalid_q;
  assign ErrCode  = err_q;
  assign RdCnt    = rdcnt_q;
  assign WrCnt    = wrcnt_q;
  assign BurstLen = blen_q;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// directed bench for cvp14_mem_responder
// LAT=1 and LAT=3 instances share stimulus
module tb_cvp14_mem_responder;

  logic        Clk1 = 1'b0;
  logic        Reset_n;
  logic [15:0] Addr;
  logic        RD, WR;
  logic [15:0] WData;
  logic        LdEn;
  logic [9:0]  LdAddr;
  logic [15:0] LdData;

  logic [15:0] rdata1, rdcnt1, wrcnt1;
  logic        rvalid1;
  logic [1:0]  err1;
  logic [4:0]  blen1;
  logic [15:0] rdata3, rdcnt3, wrcnt3;
  logic        rvalid3;
  logic [1:0]  err3;
  logic [4:0]  blen3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 Clk1 = ~Clk1;

  cvp14_mem_responder #(
    .ADDR_W(10), .BASE(16'h0000), .READ_LAT(1)
  ) u_dut (
    .Clk1(Clk1), .Reset_n(Reset_n), .Addr(Addr),
    .RD(RD), .WR(WR), .WData(WData),
    .RData(rdata1), .RValid(rvalid1),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
    .ErrCode(err1), .RdCnt(rdcnt1), .WrCnt(wrcnt1),
    .BurstLen(blen1)
  );

  cvp14_mem_responder #(
    .ADDR_W(10), .BASE(16'h0000), .READ_LAT(3)
  ) u_lat3 (
    .Clk1(Clk1), .Reset_n(Reset_n), .Addr(Addr),
    .RD(RD), .WR(WR), .WData(WData),
    .RData(rdata3), .RValid(rvalid3),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
    .ErrCode(err3), .RdCnt(rdcnt3), .WrCnt(wrcnt3),
    .BurstLen(blen3)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk1);
  endtask

  task automatic idle();
    RD = 1'b0; WR = 1'b0; LdEn = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; Addr = '0; RD = 1'b0; WR = 1'b0;
    WData = '0; LdEn = 1'b1; LdAddr = 10'd0;
    LdData = 16'h1234;
    cyc();
    LdAddr = 10'd1; LdData = 16'hABCD;
    cyc();
    LdAddr = 10'd5; LdData = 16'h5555;
    cyc();
    LdEn = 1'b0;
    cyc();
    chk("rst_rdata", rdata1, 16'h0);
    chk("rst_rvalid", rvalid1, 1'b0);
    chk("rst_err", err1, 2'b00);
    chk("rst_rdcnt", rdcnt1, 16'h0);
    chk("rst_wrcnt", wrcnt1, 16'h0);
    chk("rst_blen", blen1, 5'd0);

    Reset_n = 1'b1;
    cyc();
    RD = 1'b1; Addr = 16'h0000;
    cyc();
    chk("rd_lat_v0", rvalid1, 1'b0);
    Addr = 16'h0001;
    cyc();
    chk("rd0_data", rdata1, 16'h1234);
    chk("rd0_valid", rvalid1, 1'b1);
    RD = 1'b0;
    cyc();
    chk("rd1_data", rdata1, 16'hABCD);
    chk("rd1_valid", rvalid1, 1'b1);
    chk("rd_blen", blen1, 5'd2);
    cyc();
    chk("rd_hold", rdata1, 16'hABCD);
    chk("rd_vdrop", rvalid1, 1'b0);
    chk("rd_cnt", rdcnt1, 16'd2);

    for (int i = 0; i < 16; i++) begin
      WR = 1'b1;
      Addr = 16'h0040 + 16'(i);
      WData = 16'hA500 + 16'(i);
      cyc();
    end
    WR = 1'b0;
    cyc();
    chk("wb_blen", blen1, 5'd16);
    chk("wb_cnt", wrcnt1, 16'd16);

    for (int i = 0; i < 16; i++) begin
      RD = 1'b1;
      Addr = 16'h0040 + 16'(i);
      cyc();
      if (i > 0) begin
        chk("rb_data", rdata1, 16'hA500 + 16'(i - 1));
        chk("rb_valid", rvalid1, 1'b1);
      end
    end
    RD = 1'b0;
    cyc();
    chk("rb_last", rdata1, 16'hA50F);
    chk("rb_blen", blen1, 5'd16);
    chk("rb_rdcnt", rdcnt1, 16'd18);

    WR = 1'b1; Addr = 16'h0007; WData = 16'h7777;
    cyc();
    WR = 1'b0; RD = 1'b1;
    cyc();
    RD = 1'b0;
    cyc();
    chk("raw_data", rdata1, 16'h7777);

    RD = 1'b1; WR = 1'b1; Addr = 16'h0005;
    WData = 16'hDEAD;
    cyc();
    chk("rdwr_err", err1, 2'b01);
    idle();
    cyc();
    chk("rdwr_novld", rvalid1, 1'b0);
    RD = 1'b1;
    cyc();
    RD = 1'b0;
    cyc();
    chk("rdwr_keep", rdata1, 16'h5555);
    RD = 1'b1; Addr = 16'h0400;
    cyc();
    RD = 1'b0;
    cyc();
    chk("oor_data", rdata1, 16'h0000);
    chk("oor_valid", rvalid1, 1'b1);
    chk("oor_err", err1, 2'b01);

    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    LdEn = 1'b1; LdAddr = 10'd3; LdData = 16'h0F0F;
    WR = 1'b1; Addr = 16'h0003; WData = 16'hBEEF;
    cyc();
    chk("col_err", err1, 2'b11);
    chk("col_wrcnt", wrcnt1, 16'd0);
    idle();
    RD = 1'b1;
    cyc();
    RD = 1'b0;
    cyc();
    chk("col_data", rdata1, 16'h0F0F);

    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    cyc();
    RD = 1'b1; Addr = 16'h0000;
    cyc();
    chk("l3_v_a", rvalid3, 1'b0);
    Addr = 16'h0001;
    cyc();
    chk("l3_v_b", rvalid3, 1'b0);
    RD = 1'b0; Reset_n = 1'b0;
    cyc();
    chk("l3_v_c", rvalid3, 1'b0);
    cyc();
    chk("l3_v_d", rvalid3, 1'b0);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("l3_nov", rvalid3, 1'b0);
    end
    chk("l3_rdata0", rdata3, 16'h0);
    chk("l3_err0", err3, 2'b00);
    chk("l3_rdcnt0", rdcnt3, 16'h0);
    chk("l3_wrcnt0", wrcnt3, 16'h0);
    chk("l3_blen0", blen3, 5'd0);

    RD = 1'b1; Addr = 16'h0000;
    cyc();
    RD = 1'b0;
    cyc();
    chk("l3_w1", rvalid3, 1'b0);
    cyc();
    chk("l3_w2", rvalid3, 1'b0);
    cyc();
    chk("l3_w3", rvalid3, 1'b1);
    chk("l3_data", rdata3, 16'h1234);
    cyc();
    chk("l3_w4", rvalid3, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
